// File: rtl/mac_sequencer.sv
// Control sequencer for the MAC accelerator: runs nb_iter scalar products, pulses the streamer and
// engine start requests, and advances the stream base addresses between iterations.
module mac_sequencer #(
  parameter int unsigned CntLen = 1024,
  parameter int unsigned IterW  = 16,
  localparam int unsigned CntW  = $clog2(CntLen) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [IterW-1:0] nb_iter_i,
  input  logic [CntW-1:0]  len_i,
  input  logic [4:0]       shift_i,
  input  logic             simple_mul_i,
  input  logic [31:0]      stride_i,
  input  logic [31:0]      base_a_i,
  input  logic [31:0]      base_b_i,
  input  logic [31:0]      base_c_i,
  input  logic [31:0]      base_d_i,
  input  logic [3:0]       strm_ready_i,
  input  logic             sink_done_i,
  input  logic [CntW-1:0]  eng_cnt_i,
  input  logic             eng_acc_valid_i,
  output logic [3:0]       strm_start_o,
  output logic [31:0]      addr_a_o,
  output logic [31:0]      addr_b_o,
  output logic [31:0]      addr_c_o,
  output logic [31:0]      addr_d_o,
  output logic             eng_clear_o,
  output logic             eng_enable_o,
  output logic             eng_start_o,
  output logic             eng_simple_mul_o,
  output logic [4:0]       eng_shift_o,
  output logic [CntW-1:0]  eng_len_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IterW-1:0] iter_o
);

  typedef enum logic [2:0] {
    StIdle, StStart, StCompute, StWait, StUpdateIdx, StTerminate
  } state_e;

  state_e           state_q, state_d;
  logic [IterW-1:0] iter_q, iter_d, nb_iter_q, nb_iter_d, iter_inc;
  logic [CntW-1:0]  len_q, len_d;
  logic [4:0]       shift_q, shift_d;
  logic             smul_q, smul_d;
  logic [31:0]      stride_q, stride_d;
  logic [31:0]      addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d, addr_d_q, addr_d_d;
  logic             pend_q, pend_d;       // sink_done seen on the COMPUTE exit cycle
  logic             done_zero_q, done_zero_d;

  assign iter_inc = iter_q + IterW'(1);

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    nb_iter_d    = nb_iter_q;
    len_d        = len_q;
    shift_d      = shift_q;
    smul_d       = smul_q;
    stride_d     = stride_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    addr_c_d     = addr_c_q;
    addr_d_d     = addr_d_q;
    pend_d       = pend_q;
    done_zero_d  = 1'b0;
    strm_start_o = 4'b0000;
    eng_start_o  = 1'b0;
    eng_enable_o = 1'b0;
    eng_clear_o  = 1'b0;
    done_o       = done_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (nb_iter_i != '0 && len_i != '0) begin
            nb_iter_d = nb_iter_i;
            len_d     = len_i;
            shift_d   = shift_i;
            smul_d    = simple_mul_i;
            stride_d  = stride_i;
            addr_a_d  = base_a_i;
            addr_b_d  = base_b_i;
            addr_c_d  = base_c_i;
            addr_d_d  = base_d_i;
            iter_d    = '0;
            pend_d    = 1'b0;
            state_d   = StStart;
          end else begin
            done_zero_d = 1'b1;
          end
        end
      end
      StStart: begin
        if (&strm_ready_i) begin
          strm_start_o = 4'b1111;
          eng_start_o  = 1'b1;
          pend_d       = 1'b0;
          state_d      = StCompute;
        end
      end
      StCompute: begin
        eng_enable_o = 1'b1;
        if (eng_acc_valid_i && eng_cnt_i == len_q) begin
          pend_d  = sink_done_i;
          state_d = StWait;
        end
      end
      StWait: begin
        eng_enable_o = 1'b1;
        if (sink_done_i || pend_q) begin
          pend_d  = 1'b0;
          state_d = StUpdateIdx;
        end
      end
      StUpdateIdx: begin
        eng_clear_o = 1'b1;
        iter_d      = iter_inc;
        // Bases only advance when another iteration follows.
        if (iter_inc == nb_iter_q) begin
          state_d = StTerminate;
        end else begin
          addr_a_d = addr_a_q + stride_q;
          addr_b_d = addr_b_q + stride_q;
          addr_c_d = addr_c_q + 32'd4;
          addr_d_d = addr_d_q + 32'd4;
          state_d  = StStart;
        end
      end
      StTerminate: begin
        done_o      = 1'b1;
        eng_clear_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (clear_i) begin
      state_d      = StIdle;
      iter_d       = '0;
      pend_d       = 1'b0;
      done_zero_d  = 1'b0;
      strm_start_o = 4'b0000;
      eng_start_o  = 1'b0;
      eng_enable_o = 1'b0;
      done_o       = 1'b0;
      eng_clear_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      iter_q      <= '0;
      nb_iter_q   <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      smul_q      <= 1'b0;
      stride_q    <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      addr_d_q    <= '0;
      pend_q      <= 1'b0;
      done_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      nb_iter_q   <= nb_iter_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      smul_q      <= smul_d;
      stride_q    <= stride_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      addr_c_q    <= addr_c_d;
      addr_d_q    <= addr_d_d;
      pend_q      <= pend_d;
      done_zero_q <= done_zero_d;
    end
  end

  assign addr_a_o         = addr_a_q;
  assign addr_b_o         = addr_b_q;
  assign addr_c_o         = addr_c_q;
  assign addr_d_o         = addr_d_q;
  assign eng_simple_mul_o = smul_q;
  assign eng_shift_o      = shift_q;
  assign eng_len_o        = len_q;
  assign busy_o           = (state_q != StIdle);
  assign iter_o           = iter_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a cycle-level engine/streamer/sink model drives randomized jobs and
// checks pulses, addresses and completion against arithmetic expectations.
module tb_mac_sequencer;
  localparam int CntW  = 11;
  localparam int IterW = 16;

  logic             clk = 1'b0;
  logic             rst_ni, clear_i, start_i, simple_mul_i, sink_done_i, eng_acc_valid_i;
  logic [IterW-1:0] nb_iter_i;
  logic [CntW-1:0]  len_i, eng_cnt_i;
  logic [4:0]       shift_i;
  logic [31:0]      stride_i, base_a_i, base_b_i, base_c_i, base_d_i;
  logic [3:0]       strm_ready_i;
  logic [3:0]       strm_start_o;
  logic [31:0]      addr_a_o, addr_b_o, addr_c_o, addr_d_o;
  logic             eng_clear_o, eng_enable_o, eng_start_o, eng_simple_mul_o, busy_o, done_o;
  logic [4:0]       eng_shift_o;
  logic [CntW-1:0]  eng_len_o;
  logic [IterW-1:0] iter_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .nb_iter_i(nb_iter_i), .len_i(len_i), .shift_i(shift_i), .simple_mul_i(simple_mul_i),
    .stride_i(stride_i), .base_a_i(base_a_i), .base_b_i(base_b_i), .base_c_i(base_c_i),
    .base_d_i(base_d_i), .strm_ready_i(strm_ready_i), .sink_done_i(sink_done_i),
    .eng_cnt_i(eng_cnt_i), .eng_acc_valid_i(eng_acc_valid_i), .strm_start_o(strm_start_o),
    .addr_a_o(addr_a_o), .addr_b_o(addr_b_o), .addr_c_o(addr_c_o), .addr_d_o(addr_d_o),
    .eng_clear_o(eng_clear_o), .eng_enable_o(eng_enable_o), .eng_start_o(eng_start_o),
    .eng_simple_mul_o(eng_simple_mul_o), .eng_shift_o(eng_shift_o), .eng_len_o(eng_len_o),
    .busy_o(busy_o), .done_o(done_o), .iter_o(iter_o)
  );

  task automatic idle_inputs();
    clear_i = 0; start_i = 0; strm_ready_i = 4'h0; sink_done_i = 0;
    eng_cnt_i = '0; eng_acc_valid_i = 0;
  endtask

  // One job: cfg latched at start, then the model plays streamers/engine/sink per iteration.
  // abort_it >= 0 leaves the job when iteration abort_it enters model phase abort_ph.
  task automatic run_job(input int nb, input int len, input logic [31:0] stride,
                         input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc,
                         input logic [31:0] bd, input int stall_lo, input int stall_hi,
                         input logic [3:0] part, input int sd_lo, input int sd_hi,
                         input bit noise, input int abort_it, input int abort_ph);
    int starts = 0, ph = 0, cur = 0, cnt_drv = 0, sdly = 0, stall;
    bit fin = 0, seen_done = 0, rdy_full;
    logic [4:0] shv = 5'($urandom);
    logic sm = 1'($urandom);
    logic [31:0] ea, eb, ec, ed;
    @(negedge clk);
    idle_inputs();
    start_i = 1; nb_iter_i = IterW'(nb); len_i = CntW'(len); stride_i = stride;
    base_a_i = ba; base_b_i = bb; base_c_i = bc; base_d_i = bd; shift_i = shv; simple_mul_i = sm;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_pre_start: got %b want 0", busy_o); end
    stall = $urandom_range(stall_hi, stall_lo);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      cur = ph;
      start_i = noise ? 1'($urandom) : 1'b0;
      if (noise) begin
        nb_iter_i = IterW'($urandom); len_i = CntW'($urandom); stride_i = $urandom;
        base_a_i = $urandom; base_d_i = $urandom; shift_i = 5'($urandom); simple_mul_i = ~sm;
      end
      strm_ready_i = 4'hF; eng_acc_valid_i = 0; sink_done_i = 0;
      case (cur)
        0: if (stall > 0) begin strm_ready_i = part; stall--; end
        1: begin
          cnt_drv++;
          eng_cnt_i = CntW'(cnt_drv);
          eng_acc_valid_i = 1'($urandom);  // valid without full count must not end COMPUTE
          if (cnt_drv == len) begin
            eng_acc_valid_i = 1;
            sdly = $urandom_range(sd_hi, sd_lo);
            if (sdly == 0) begin sink_done_i = 1; ph = 0; stall = $urandom_range(stall_hi, stall_lo); end
            else ph = 2;
          end
        end
        default: begin
          sdly--;
          if (sdly == 0) begin sink_done_i = 1; ph = 0; stall = $urandom_range(stall_hi, stall_lo); end
        end
      endcase
      rdy_full = (strm_ready_i == 4'hF);
      #1;
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_job: got %b want 1", busy_o); end
      checks++;
      if (eng_start_o !== (strm_start_o == 4'hF)) begin
        errors++; $display("FAIL start_pair: eng_start %b strm_start %h", eng_start_o, strm_start_o);
      end
      if (strm_start_o !== 4'h0) begin
        checks++;
        if (!(cur == 0 && rdy_full && strm_start_o == 4'hF && starts < nb)) begin
          errors++;
          $display("FAIL strm_start: got %h phase %0d ready %h starts %0d", strm_start_o, cur,
                   strm_ready_i, starts);
        end else begin
          ea = ba + 32'(starts) * stride; eb = bb + 32'(starts) * stride;
          ec = bc + 32'(starts) * 32'd4;  ed = bd + 32'(starts) * 32'd4;
          checks++;
          if ({addr_a_o, addr_b_o, addr_c_o, addr_d_o} !== {ea, eb, ec, ed}) begin
            errors++;
            $display("FAIL addr_iter%0d: got %h %h %h %h want %h %h %h %h", starts, addr_a_o,
                     addr_b_o, addr_c_o, addr_d_o, ea, eb, ec, ed);
          end
          checks++;
          if ({iter_o, eng_len_o, eng_shift_o, eng_simple_mul_o} !==
              {IterW'(starts), CntW'(len), shv, sm}) begin
            errors++;
            $display("FAIL cfg_iter%0d: got iter %0d len %0d sh %0d sm %b want %0d %0d %0d %b",
                     starts, iter_o, eng_len_o, eng_shift_o, eng_simple_mul_o, starts, len, shv, sm);
          end
          starts++; ph = 1; cnt_drv = 0;
        end
      end
      if (cur != 0) begin
        checks++;
        if ({eng_enable_o, eng_clear_o, done_o} !== 3'b100) begin
          errors++;
          $display("FAIL run_ctrl: got en/clr/done %b%b%b want 100", eng_enable_o, eng_clear_o,
                   done_o);
        end
      end
      if (done_o === 1'b1) begin
        ea = ba + 32'(nb - 1) * stride; ed = bd + 32'(nb - 1) * 32'd4;
        checks++;
        if (starts != nb || cur != 0 || eng_clear_o !== 1'b1 || addr_a_o !== ea ||
            addr_d_o !== ed) begin
          errors++;
          $display("FAIL done_state: starts %0d/%0d clr %b addr_a %h/%h addr_d %h/%h", starts,
                   nb, eng_clear_o, addr_a_o, ea, addr_d_o, ed);
        end
        fin = 1; seen_done = 1;
      end
      if (abort_it >= 0 && starts == abort_it + 1 && ph == abort_ph) fin = 1;
    end
    if (abort_it < 0) begin
      checks++;
      if (!seen_done) begin errors++; $display("FAIL job_timeout: got no done want done"); end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if ({busy_o, done_o, strm_start_o} !== 6'b0) begin
        errors++; $display("FAIL after_done: busy %b done %b strm %h want 0", busy_o, done_o,
                           strm_start_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 0; idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({strm_start_o, addr_a_o, addr_b_o, addr_c_o, addr_d_o, eng_clear_o, eng_enable_o,
         eng_start_o, eng_simple_mul_o, eng_shift_o, eng_len_o, busy_o, done_o, iter_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero want all 0 (busy %b)", busy_o);
    end
    rst_ni = 1;
  endtask

  task automatic test_single();
    run_job(1, 4, 32'h40, 32'hA000, 32'hB000, 32'hC000, 32'hD000, 0, 0, 4'h7, 2, 2, 0, -1, 0);
  endtask

  task automatic test_multi();
    run_job(3, 8, 32'd32, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 0, 1, 4'h7, 1, 2, 0, -1, 0);
  endtask

  task automatic test_stall();
    run_job(2, 3, 32'd16, 32'h100, 32'h200, 32'h300, 32'h400, 5, 5, 4'b1011, 1, 1, 0, -1, 0);
  endtask

  task automatic test_coincident_sink();
    run_job(3, 2, 32'd8, 32'h0, 32'h80, 32'h100, 32'h180, 0, 0, 4'h7, 0, 0, 0, -1, 0);
  endtask

  task automatic test_zero_len();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle_inputs();
      start_i = 1; nb_iter_i = (k == 0) ? '0 : IterW'(3); len_i = (k == 0) ? CntW'(5) : '0;
      #1;
      checks++;
      if ({done_o, busy_o} !== 2'b00) begin
        errors++; $display("FAIL zero_cfg_early%0d: done %b busy %b want 00", k, done_o, busy_o);
      end
      @(negedge clk);
      start_i = 0;
      #1;
      checks++;
      if ({done_o, busy_o, strm_start_o} !== 6'b100000) begin
        errors++; $display("FAIL zero_cfg_done%0d: done %b busy %b strm %h want 1 0 0", k, done_o,
                           busy_o, strm_start_o);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({done_o, busy_o} !== 2'b00) begin
        errors++; $display("FAIL zero_cfg_after%0d: done %b busy %b want 00", k, done_o, busy_o);
      end
    end
  endtask

  task automatic test_clear();
    run_job(3, 6, 32'd64, 32'h5000, 32'h6000, 32'h7000, 32'h8000, 0, 0, 4'h7, 2, 2, 0, 1, 1);
    @(negedge clk);
    idle_inputs();
    clear_i = 1; start_i = 1; nb_iter_i = IterW'(4); len_i = CntW'(3);
    #1;
    checks++;
    if ({eng_clear_o, done_o, eng_enable_o, strm_start_o} !== 7'b1000000) begin
      errors++; $display("FAIL clear_cycle: clr %b done %b en %b strm %h want 1 0 0 0", eng_clear_o,
                         done_o, eng_enable_o, strm_start_o);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({busy_o, done_o, iter_o} !== '0) begin
      errors++; $display("FAIL after_clear: busy %b done %b iter %0d want 0", busy_o, done_o, iter_o);
    end
    run_job(2, 4, 32'd4, 32'h9000, 32'h9100, 32'h9200, 32'h9300, 0, 2, 4'h3, 0, 2, 0, -1, 0);
  endtask

  task automatic test_start_while_busy();
    run_job(3, 5, 32'h20, 32'h1111_0000, 32'h2222_0000, 32'h3330, 32'h4440, 0, 2, 4'h5, 0, 3, 1,
            -1, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(4, 1), $urandom_range(12, 1), $urandom, $urandom, $urandom,
              32'hFFFF_FFF8, $urandom, 0, 3, 4'($urandom_range(14, 0)), 0, 3, 1'($urandom), -1, 0);
    end
  endtask

  task automatic test_reset_mid_wait();
    run_job(2, 3, 32'd16, 32'hAAA0, 32'hBBB0, 32'hCCC0, 32'hDDD0, 0, 0, 4'h7, 10, 10, 0, 0, 2);
    @(negedge clk);
    idle_inputs();
    rst_ni = 0;
    @(negedge clk);
    #1;
    checks++;
    if ({strm_start_o, addr_a_o, addr_b_o, addr_c_o, addr_d_o, eng_clear_o, eng_enable_o,
         eng_start_o, eng_simple_mul_o, eng_shift_o, eng_len_o, busy_o, done_o, iter_o} !== '0) begin
      errors++; $display("FAIL reset_mid_wait: busy %b en %b addr_a %h want all 0", busy_o,
                         eng_enable_o, addr_a_o);
    end
    rst_ni = 1;
    run_job(1, 2, 32'd0, 32'h10, 32'h20, 32'h30, 32'h40, 0, 0, 4'h7, 1, 1, 0, -1, 0);
  endtask

  initial begin
    nb_iter_i = '0; len_i = '0; shift_i = '0; simple_mul_i = 0; stride_i = '0;
    base_a_i = '0; base_b_i = '0; base_c_i = '0; base_d_i = '0;
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_coincident_sink();
    test_zero_len();
    test_clear();
    test_start_while_busy();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
